comparator_pipe: RTL and testbench

Parametrised, pipelined successor to the 4-bit combinational magnitude comparator. Compares two WIDTH-bit operands (unsigned or two's-complement, selected per sample) with a valid-qualified 2-stage pipeline, and produces the 3-bit one-hot P result. Also provides a change-detect pulse and saturating per-outcome event counters. Used wherever a registered compare result and outcome statistics are needed, e.g. threshold monitors and sort/select datapaths.

---
 rtl/comparator_pipe_if.sv | 29 ++
 rtl/comparator_pipe.sv | 52 +++++
 tb/tb_comparator_pipe.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/comparator_pipe_if.sv
// comparator_pipe_if: sample inputs (valid/signed/A/B/clr) and registered results (valid/P/chg/cnt_*) of comparator_pipe; slave = DUT side
interface comparator_pipe_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic             comparator_pipe_port_valid;
  logic             comparator_pipe_port_signed;
  logic [WIDTH-1:0] comparator_pipe_port_A;
  logic [WIDTH-1:0] comparator_pipe_port_B;
  logic             comparator_pipe_port_clr;
  logic             comparator_pipe_oport_valid;
  logic [2:0]       comparator_pipe_oport_P;
  logic             comparator_pipe_oport_chg;
  logic [CNT_W-1:0] comparator_pipe_oport_cnt_gt;
  logic [CNT_W-1:0] comparator_pipe_oport_cnt_eq;
  logic [CNT_W-1:0] comparator_pipe_oport_cnt_lt;
  modport master (
    output comparator_pipe_port_valid, comparator_pipe_port_signed,
           comparator_pipe_port_A, comparator_pipe_port_B, comparator_pipe_port_clr,
    input  comparator_pipe_oport_valid, comparator_pipe_oport_P, comparator_pipe_oport_chg,
           comparator_pipe_oport_cnt_gt, comparator_pipe_oport_cnt_eq, comparator_pipe_oport_cnt_lt
  );
  modport slave (
    input  comparator_pipe_port_valid, comparator_pipe_port_signed,
           comparator_pipe_port_A, comparator_pipe_port_B, comparator_pipe_port_clr,
    output comparator_pipe_oport_valid, comparator_pipe_oport_P, comparator_pipe_oport_chg,
           comparator_pipe_oport_cnt_gt, comparator_pipe_oport_cnt_eq, comparator_pipe_oport_cnt_lt
  );
endinterface

// File: rtl/comparator_pipe.sv
// comparator_pipe: 2-stage signed/unsigned compare with change pulse and saturating counters; ports clk, rst_n (sync, active-low), bus (slave)
module comparator_pipe #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic            comparator_pipe_port_clk,
  input  logic            comparator_pipe_port_rst_n,
  comparator_pipe_if.slave bus
);
  logic             s1_valid, s1_sgn;
  logic [WIDTH-1:0] s1_a, s1_b, ka, kb;
  logic [2:0]       p, p_q;
  logic             v_q, chg_q, has_prev;
  logic [CNT_W-1:0] cnt [3];
  // flipping the sign bit maps two's-complement order onto unsigned order
  always_comb begin
    ka = {s1_a[WIDTH-1] ^ s1_sgn, s1_a[WIDTH-2:0]};
    kb = {s1_b[WIDTH-1] ^ s1_sgn, s1_b[WIDTH-2:0]};
    p  = {ka > kb, s1_a == s1_b, ka < kb};
  end
  always_ff @(posedge comparator_pipe_port_clk) begin
    s1_valid <= comparator_pipe_port_rst_n && bus.comparator_pipe_port_valid;
    if (comparator_pipe_port_rst_n && bus.comparator_pipe_port_valid) begin
      s1_a   <= bus.comparator_pipe_port_A;
      s1_b   <= bus.comparator_pipe_port_B;
      s1_sgn <= bus.comparator_pipe_port_signed;
    end
  end
  // p_q doubles as the previous-result history; has_prev qualifies it
  always_ff @(posedge comparator_pipe_port_clk) begin
    if (!comparator_pipe_port_rst_n) begin
      v_q      <= 1'b0;
      p_q      <= 3'b000;
      chg_q    <= 1'b0;
      has_prev <= 1'b0;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      v_q      <= s1_valid;
      chg_q    <= s1_valid && has_prev && !bus.comparator_pipe_port_clr && p != p_q;
      p_q      <= s1_valid ? p : p_q;
      has_prev <= !bus.comparator_pipe_port_clr && (has_prev || s1_valid);
      for (int i = 0; i < 3; i++)
        cnt[i] <= bus.comparator_pipe_port_clr ? '0 : cnt[i] + CNT_W'(s1_valid && p[i] && cnt[i] != '1);
    end
  end
  assign bus.comparator_pipe_oport_valid  = v_q;
  assign bus.comparator_pipe_oport_P      = p_q;
  assign bus.comparator_pipe_oport_chg    = chg_q;
  assign bus.comparator_pipe_oport_cnt_lt = cnt[0];
  assign bus.comparator_pipe_oport_cnt_eq = cnt[1];
  assign bus.comparator_pipe_oport_cnt_gt = cnt[2];
endmodule

// File: tb/tb_comparator_pipe.sv
// tb_comparator_pipe: randomized and directed checks of comparator_pipe against a queue-based reference model
module tb_comparator_pipe;
  logic clk = 0, rst_n = 0, valid = 0, sgn = 0, clr = 0;
  logic [3:0] a = 0, b = 0;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  comparator_pipe_if #(.WIDTH(4), .CNT_W(8)) bi ();
  comparator_pipe_if #(.WIDTH(4), .CNT_W(2)) bs ();
  assign bi.comparator_pipe_port_valid  = valid;
  assign bi.comparator_pipe_port_signed = sgn;
  assign bi.comparator_pipe_port_A      = a;
  assign bi.comparator_pipe_port_B      = b;
  assign bi.comparator_pipe_port_clr    = clr;
  assign bs.comparator_pipe_port_valid  = valid;
  assign bs.comparator_pipe_port_signed = sgn;
  assign bs.comparator_pipe_port_A      = a;
  assign bs.comparator_pipe_port_B      = b;
  assign bs.comparator_pipe_port_clr    = clr;
  comparator_pipe #(.WIDTH(4), .CNT_W(8)) dut (
    .comparator_pipe_port_clk(clk), .comparator_pipe_port_rst_n(rst_n), .bus(bi.slave));
  comparator_pipe #(.WIDTH(4), .CNT_W(2)) dut_sat (
    .comparator_pipe_port_clk(clk), .comparator_pipe_port_rst_n(rst_n), .bus(bs.slave));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] ref_p(input logic [3:0] x, input logic [3:0] y, input logic s);
    int ix, iy;
    ix = int'(x) - ((s && x[3]) ? 16 : 0);
    iy = int'(y) - ((s && y[3]) ? 16 : 0);
    return {ix > iy, ix == iy, ix < iy};
  endfunction

  function automatic int sat(input int c, input int m);
    return c > m ? m : c;
  endfunction

  typedef struct { int due; logic [2:0] p; } pend_t;
  pend_t pend[$];
  int cyc = 0, cg = 0, ce = 0, cl = 0;
  bit started = 0, has_prev = 0;
  logic e_v = 0, e_chg = 0;
  logic [2:0] e_p = 0, r_m;

  always @(posedge clk) begin
    cyc++;
    started = 1;
    if (!rst_n) begin
      pend.delete();
      e_v = 0; e_p = 0; e_chg = 0; cg = 0; ce = 0; cl = 0; has_prev = 0;
    end else begin
      e_v = 0;
      e_chg = 0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        r_m = pend[0].p;
        void'(pend.pop_front());
        e_v = 1;
      end
      if (e_v) begin
        e_chg = !clr && has_prev && r_m != e_p;
        e_p = r_m;
        has_prev = 1;
        if (r_m == 3'b100) cg++; else if (r_m == 3'b010) ce++; else cl++;
      end
      if (clr) begin cg = 0; ce = 0; cl = 0; has_prev = 0; end
      if (valid) pend.push_back('{cyc + 1, ref_p(a, b, sgn)});
    end
  end

  always @(negedge clk) if (started) begin
    chk("valid", bi.comparator_pipe_oport_valid, e_v);
    chk("P", bi.comparator_pipe_oport_P, e_p);
    chk("chg", bi.comparator_pipe_oport_chg, e_chg);
    chk("cnt_gt", bi.comparator_pipe_oport_cnt_gt, sat(cg, 255));
    chk("cnt_eq", bi.comparator_pipe_oport_cnt_eq, sat(ce, 255));
    chk("cnt_lt", bi.comparator_pipe_oport_cnt_lt, sat(cl, 255));
    chk("sat_valid", bs.comparator_pipe_oport_valid, e_v);
    chk("sat_P", bs.comparator_pipe_oport_P, e_p);
    chk("sat_cnt_gt", bs.comparator_pipe_oport_cnt_gt, sat(cg, 3));
    chk("sat_cnt_eq", bs.comparator_pipe_oport_cnt_eq, sat(ce, 3));
    chk("sat_cnt_lt", bs.comparator_pipe_oport_cnt_lt, sat(cl, 3));
  end

  logic [7:0] vpat = 8'b0001_1001, vexp = 8'b0011_0010;

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_valid", bi.comparator_pipe_oport_valid, 0);
    chk("rst_P", bi.comparator_pipe_oport_P, 0);
    chk("rst_cnt_eq", bi.comparator_pipe_oport_cnt_eq, 0);
    rst_n = 1;
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++) begin
        a = 4'(i); b = 4'(j); valid = 1;
        @(negedge clk);
      end
    valid = 0;
    repeat (2) @(negedge clk);
    chk("exh_cnt_gt", bi.comparator_pipe_oport_cnt_gt, 120);
    chk("exh_cnt_eq", bi.comparator_pipe_oport_cnt_eq, 16);
    chk("exh_cnt_lt", bi.comparator_pipe_oport_cnt_lt, 120);
    chk("exh_sat_eq", bs.comparator_pipe_oport_cnt_eq, 3);
    clr = 1;
    @(negedge clk);
    clr = 0; a = 4'b1000; b = 4'b0111; sgn = 0; valid = 1;
    @(negedge clk);
    sgn = 1;
    @(negedge clk);
    valid = 0;
    chk("uns_P", bi.comparator_pipe_oport_P, 3'b100);
    chk("uns_chg", bi.comparator_pipe_oport_chg, 0);
    @(negedge clk);
    chk("sgn_P", bi.comparator_pipe_oport_P, 3'b001);
    chk("sgn_chg", bi.comparator_pipe_oport_chg, 1);
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      a = 4'($urandom); b = 4'($urandom); valid = vpat[i];
      @(negedge clk);
      chk("gap_valid", bi.comparator_pipe_oport_valid, vexp[i]);
    end
    clr = 1;
    @(negedge clk);
    clr = 0; a = 5; b = 5; sgn = 0; valid = 1;
    repeat (6) @(negedge clk);
    valid = 0;
    repeat (2) @(negedge clk);
    chk("satur_eq", bs.comparator_pipe_oport_cnt_eq, 3);
    chk("satur_gt", bs.comparator_pipe_oport_cnt_gt, 0);
    chk("satur_lt", bs.comparator_pipe_oport_cnt_lt, 0);
    chk("satur_main_eq", bi.comparator_pipe_oport_cnt_eq, 6);
    a = 9; b = 2; valid = 1;
    @(negedge clk);
    a = 3; b = 1; clr = 1;
    @(negedge clk);
    valid = 0; clr = 0;
    chk("coll_valid", bi.comparator_pipe_oport_valid, 1);
    chk("coll_P", bi.comparator_pipe_oport_P, 3'b100);
    chk("coll_chg", bi.comparator_pipe_oport_chg, 0);
    chk("coll_cnt_gt", bi.comparator_pipe_oport_cnt_gt, 0);
    chk("coll_cnt_eq", bi.comparator_pipe_oport_cnt_eq, 0);
    @(negedge clk);
    chk("coll2_valid", bi.comparator_pipe_oport_valid, 1);
    chk("coll2_cnt_gt", bi.comparator_pipe_oport_cnt_gt, 1);
    chk("coll2_chg", bi.comparator_pipe_oport_chg, 0);
    a = 1; b = 2; valid = 1;
    @(negedge clk);
    a = 2; b = 1; rst_n = 0;
    @(negedge clk);
    rst_n = 1; valid = 0;
    chk("mrst_valid", bi.comparator_pipe_oport_valid, 0);
    chk("mrst_P", bi.comparator_pipe_oport_P, 0);
    chk("mrst_cnt_gt", bi.comparator_pipe_oport_cnt_gt, 0);
    repeat (3) begin
      @(negedge clk);
      chk("mrst_quiet", bi.comparator_pipe_oport_valid, 0);
    end
    a = 7; b = 7; valid = 1;
    @(negedge clk);
    valid = 0;
    chk("mrst_lat1", bi.comparator_pipe_oport_valid, 0);
    @(negedge clk);
    chk("mrst_lat2", bi.comparator_pipe_oport_valid, 1);
    chk("mrst_P2", bi.comparator_pipe_oport_P, 3'b010);
    repeat (3000) begin
      valid = ($urandom % 4) != 0;
      sgn = 1'($urandom);
      a = 4'($urandom_range(0, 15));
      b = ($urandom % 4 == 0) ? a : 4'($urandom_range(0, 15));
      clr = ($urandom % 16) == 0;
      rst_n = ($urandom % 64) != 0;
      @(negedge clk);
    end
    rst_n = 1; valid = 0; clr = 0;
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
